// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions.
// Provides the default datapath widths, the bit positions inside the
// 5-bit execute control field, the packed EX->MEM entry record, and the
// occupancy encoding used by the 2-entry skid buffer.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTL_W  = 5;

    // ex_ctl = {branch, mem_read, mem_write, reg_write, mem_to_reg}
    localparam int unsigned BR_BIT  = 4;
    localparam int unsigned MR_BIT  = 3;
    localparam int unsigned MW_BIT  = 2;
    localparam int unsigned RW_BIT  = 1;
    localparam int unsigned M2R_BIT = 0;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd;
        logic [CTL_W-1:0]  ctl;
        logic [DATA_W-1:0] br_target;
    } ex_mem_entry_t;

    // Skid buffer occupancy: nothing, head only, head plus skid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HEAD  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer carrying ex_mem_entry_t.
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   flush                 synchronous drop of both entries (out-transfer
//                         in the same cycle still completes)
//   in_valid/in_ready     upstream handshake; in_ready is registered
//   in_data               entry offered by upstream
//   out_valid/out_ready   downstream handshake; out_valid = head valid
//   out_data              head entry, held stable while stalled
module pipe_skid_buf
    import pipe_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  ex_mem_entry_t in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output ex_mem_entry_t out_data
);

    occ_t          state;
    occ_t          state_next;
    ex_mem_entry_t head_q;
    ex_mem_entry_t head_next;
    ex_mem_entry_t skid_q;
    ex_mem_entry_t skid_next;
    logic          ready_q;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer   = in_valid && ready_q;
    assign out_xfer  = (state != OCC_EMPTY) && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = head_q;

    always_comb begin
        state_next = state;
        head_next  = head_q;
        skid_next  = skid_q;
        if (flush) begin
            // Payloads are left in place; only occupancy is dropped.
            state_next = OCC_EMPTY;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        head_next  = in_data;
                        state_next = OCC_HEAD;
                    end
                end
                OCC_HEAD: begin
                    if (in_xfer && out_xfer) begin
                        head_next = in_data;
                    end else if (in_xfer) begin
                        skid_next  = in_data;
                        state_next = OCC_FULL;
                    end else if (out_xfer) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so no in-transfer can occur.
                    if (out_xfer) begin
                        head_next  = skid_q;
                        state_next = OCC_HEAD;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            head_q  <= head_next;
            skid_q  <= skid_next;
            // Registered ready: low exactly when the skid slot will be occupied.
            ready_q <= (state_next != OCC_FULL);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage.
// Captures ALU result, Zero flag, store data, destination register and
// control bits from EX into a 2-entry skid buffer and presents the head
// entry to MEM over valid/ready. Taken branches (branch && zero) are
// resolved as the entry leaves toward MEM: pc_src pulses for one cycle
// with pc_target holding the branch target.
// Ports:
//   clock, reset_n                      clock, async active-low reset
//   ex_valid/ex_ready                   EX handshake (ex_ready registered)
//   ex_alu_out, ex_zero, ex_store_data,
//   ex_rd, ex_ctl, ex_br_target         EX payload
//   flush                               drop all held entries
//   mem_valid/mem_ready                 MEM handshake
//   mem_alu_out, mem_store_data,
//   mem_rd, mem_ctl                     head payload to MEM
//   pc_src, pc_target                   taken-branch redirect
// Optional (macro EX_MEM_FWD_EN): fwd_valid, fwd_rd, fwd_data taps of
// the head entry for the EX forwarding mux.
module ex_mem_stage #(
    parameter int unsigned DATA_W = pipe_pkg::DATA_W,
    parameter int unsigned REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [4:0]        ex_ctl,
    input  logic [DATA_W-1:0] ex_br_target,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic [3:0]        mem_ctl,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target
`ifdef EX_MEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    import pipe_pkg::*;

    ex_mem_entry_t in_entry;
    ex_mem_entry_t head;
    logic          head_branch;
    logic          taken;

    always_comb begin
        in_entry            = '0;
        in_entry.alu_out    = ex_alu_out;
        in_entry.zero       = ex_zero;
        in_entry.store_data = ex_store_data;
        in_entry.rd         = ex_rd;
        in_entry.ctl        = ex_ctl;
        in_entry.br_target  = ex_br_target;
    end

    pipe_skid_buf u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_entry),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (head)
    );

    assign head_branch    = head.ctl[BR_BIT];
    assign mem_alu_out    = head.alu_out;
    assign mem_store_data = head.store_data;
    assign mem_rd         = head.rd;
    // Branches carry no memory or writeback side effects downstream.
    assign mem_ctl        = head_branch ? 4'b0000
                          : {head.ctl[MR_BIT], head.ctl[MW_BIT],
                             head.ctl[RW_BIT], head.ctl[M2R_BIT]};

    // Flush does not gate this: an out-transfer in the flush cycle completes.
    assign taken = mem_valid && mem_ready && head_branch && head.zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_src    <= 1'b0;
            pc_target <= '0;
        end else begin
            pc_src <= taken;
            if (taken) begin
                pc_target <= head.br_target;
            end
        end
    end

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = mem_valid && mem_ctl[1] && !mem_ctl[3] && (head.rd != '0);
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.alu_out;
`endif

endmodule
